// File: rtl/bpred_pkg.sv
// bpred_pkg: shared BTB types, entry layout helpers, counter and PC field functions
package bpred_pkg;

    typedef enum logic {ST_CLEAR, ST_RUN} btb_state_t;

    // Entry layout for the default TAG_W=8 / CTR_W=2 build, MSB first.
    typedef struct packed {
        logic        valid;
        logic [7:0]  tag;
        logic [31:0] target;
        logic [1:0]  ctr;
    } btb_entry_t;

    function automatic int entry_w(input int tag_w, input int ctr_w);
        return 1 + tag_w + 32 + ctr_w;
    endfunction

    // Counter MSB set, all lower bits clear.
    function automatic logic [31:0] WEAK_TAKEN(input int ctr_w);
        return 32'd1 << (ctr_w - 1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] c, input int ctr_w);
        logic [31:0] mx;
        mx = (32'd1 << ctr_w) - 32'd1;
        return (c >= mx) ? mx : c + 32'd1;
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] c);
        return (c == 32'd0) ? 32'd0 : c - 32'd1;
    endfunction

    function automatic logic [31:0] bpred_idx(input logic [31:0] pc, input int idx_w);
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] bpred_tag(input logic [31:0] pc, input int idx_w, input int tag_w);
        return (pc >> (2 + idx_w)) & ((32'd1 << tag_w) - 32'd1);
    endfunction

endpackage

// File: rtl/bpred_ram.sv
// bpred_ram: BTB entry storage, one synchronous read-first read port and one bit-masked write port
module bpred_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 43,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] wr_mask
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Masked write and read-first read: the read sees the array as it was before this edge's write.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= (mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/bpred_btb.sv
// bpred_btb: tagged branch target buffer with saturating direction counters and a clear sweep
module bpred_btb
    import bpred_pkg::*;
#(
    parameter int ENTRIES = 1024,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lookup_en,
    input  logic [31:0]      lookup_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    output logic [CTR_W-1:0] pred_ctr,
    input  logic             upd_en,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_hit,
    input  logic [CTR_W-1:0] upd_ctr,
    input  logic             flush,
    output logic             busy
);

    localparam int IDX_W  = $clog2(ENTRIES);
    localparam int E_W    = entry_w(TAG_W, CTR_W);
    localparam int TGT_LO = CTR_W;
    localparam int TAG_LO = CTR_W + 32;
    localparam logic [E_W-1:0] CTR_MASK = {{(E_W-CTR_W){1'b0}}, {CTR_W{1'b1}}};
    localparam logic [E_W-1:0] TGT_MASK = {{(1+TAG_W){1'b0}}, {(32+CTR_W){1'b1}}};

    btb_state_t       state;
    logic [IDX_W-1:0] clr_idx;
    logic [IDX_W-1:0] wr_addr;
    logic [TAG_W-1:0] look_tag;
    logic             look_ok;
    logic [E_W-1:0]   rd_data;
    logic [E_W-1:0]   wr_data;
    logic [E_W-1:0]   wr_mask;
    logic             wr_en;
    logic             upd_go;
    logic             hit;
    logic [CTR_W-1:0] new_ctr;

    assign upd_go  = (state == ST_RUN) && upd_en && !flush && (upd_hit || upd_taken);
    assign new_ctr = !upd_hit  ? CTR_W'(WEAK_TAKEN(CTR_W)) :
                     upd_taken ? CTR_W'(sat_inc(32'(upd_ctr), CTR_W)) :
                                 CTR_W'(sat_dec(32'(upd_ctr)));

    // Write port: the sweep owns it while clearing, otherwise resolved branches write the fields they change.
    always_comb begin
        wr_en   = (state == ST_CLEAR) || upd_go;
        wr_addr = (state == ST_CLEAR) ? clr_idx : IDX_W'(bpred_idx(upd_pc, IDX_W));
        wr_data = (state == ST_CLEAR) ? '0 :
                  {1'b1, TAG_W'(bpred_tag(upd_pc, IDX_W, TAG_W)), upd_target, new_ctr};
        wr_mask = ((state == ST_CLEAR) || !upd_hit) ? '1 : (upd_taken ? TGT_MASK : CTR_MASK);
    end

    // Sweep FSM: flush or reset restarts the clear from index 0; the last index hands over to RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
            busy    <= 1'b1;
        end else if (flush) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
            busy    <= 1'b1;
        end else if (state == ST_CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
            if (&clr_idx) begin
                state <= ST_RUN;
                busy  <= 1'b0;
            end
        end
    end

    // Lookup side state: remembers the tag to compare and whether the read may report a hit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            look_ok  <= 1'b0;
            look_tag <= '0;
        end else if (lookup_en) begin
            look_ok  <= (state == ST_RUN);
            look_tag <= TAG_W'(bpred_tag(lookup_pc, IDX_W, TAG_W));
        end
    end

    bpred_ram #(
        .DEPTH(ENTRIES),
        .WIDTH(E_W),
        .AW   (IDX_W)
    ) u_ram (
        .clk    (clk),
        .rd_en  (lookup_en),
        .rd_addr(IDX_W'(bpred_idx(lookup_pc, IDX_W))),
        .rd_data(rd_data),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_mask(wr_mask)
    );

    assign hit         = look_ok && rd_data[E_W-1] && (rd_data[TAG_LO +: TAG_W] == look_tag);
    assign pred_hit    = hit;
    assign pred_taken  = hit && rd_data[CTR_W-1];
    assign pred_target = hit ? rd_data[TGT_LO +: 32] : '0;
    assign pred_ctr    = hit ? rd_data[CTR_W-1:0] : '0;

endmodule

// File: tb/tb_bpred_btb.sv
// tb_bpred_btb: scoreboard bench for bpred_btb against an array-based reference model
module tb_bpred_btb;

    localparam int N = 16;

    typedef struct packed {
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
        logic [1:0]  ctr;
    } pred_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lookup_en = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [1:0]  pred_ctr;
    logic        upd_en = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_hit = 1'b0;
    logic [1:0]  upd_ctr = '0;
    logic        flush = 1'b0;
    logic        busy;

    always #5 clk = ~clk;

    bpred_btb #(.ENTRIES(N), .TAG_W(8), .CTR_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .lookup_en  (lookup_en),
        .lookup_pc  (lookup_pc),
        .pred_hit   (pred_hit),
        .pred_taken (pred_taken),
        .pred_target(pred_target),
        .pred_ctr   (pred_ctr),
        .upd_en     (upd_en),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target),
        .upd_hit    (upd_hit),
        .upd_ctr    (upd_ctr),
        .flush      (flush),
        .busy       (busy)
    );

    int    n_cmp = 0;
    int    n_bad = 0;
    pred_t exp_q[$];
    pred_t last = '0;
    logic  lk_q;

    bit          m_valid[N];
    int          m_tag[N];
    logic [31:0] m_tgt[N];
    int          m_ctr[N];
    int          clear_left = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int pc_idx(logic [31:0] pc);
        return int'((pc / 4) % N);
    endfunction

    function automatic int pc_tag(logic [31:0] pc);
        return int'((pc / (4 * N)) % 256);
    endfunction

    function automatic pred_t model_look(logic [31:0] pc);
        pred_t p = '0;
        int    i = pc_idx(pc);
        if (clear_left == 0 && m_valid[i] && m_tag[i] == pc_tag(pc)) begin
            p.hit   = 1'b1;
            p.taken = (m_ctr[i] >= 2);
            p.tgt   = m_tgt[i];
            p.ctr   = 2'(m_ctr[i]);
        end
        return p;
    endfunction

    function automatic void model_clear_all();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        clear_left = N;
    endfunction

    function automatic void model_edge();
        int i = pc_idx(upd_pc);
        int c = int'(upd_ctr);
        if (flush) model_clear_all();
        else if (clear_left > 0) clear_left--;
        else if (upd_en) begin
            if (upd_hit) begin
                m_ctr[i] = upd_taken ? ((c + 1 > 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
                if (upd_taken) m_tgt[i] = upd_target;
            end else if (upd_taken) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = pc_tag(upd_pc);
                m_tgt[i]   = upd_target;
                m_ctr[i]   = 2;
            end
        end
    endfunction

    task automatic tick();
        if (lookup_en) exp_q.push_back(model_look(lookup_pc));
        model_edge();
        @(posedge clk);
        #1;
        chk("busy", 32'(busy), 32'(clear_left > 0));
        lookup_en = 1'b0;
        upd_en    = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc);
        lookup_en = 1'b1;
        lookup_pc = pc;
        tick();
    endtask

    task automatic update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic h, input logic [1:0] c);
        upd_en     = 1'b1;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tgt;
        upd_hit    = h;
        upd_ctr    = c;
        tick();
    endtask

    task automatic expect_out(string name, logic h, logic tk, logic [31:0] tgt, logic [1:0] c);
        chk({name, "_hit"}, 32'(pred_hit), 32'(h));
        chk({name, "_taken"}, 32'(pred_taken), 32'(tk));
        chk({name, "_target"}, pred_target, tgt);
        chk({name, "_ctr"}, 32'(pred_ctr), 32'(c));
    endtask

    // Tracks which edges sampled a lookup, so the monitor knows when a new prediction appears.
    always @(posedge clk or negedge rst) begin
        if (!rst) lk_q <= 1'b0;
        else lk_q <= lookup_en;
    end

    // Monitor: pops a fresh expectation when a lookup lands, otherwise the outputs must hold.
    always @(negedge clk) begin
        if (lk_q) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_underflow at %0t", $time);
            end else last = exp_q.pop_front();
        end
        chk("sb_hit", 32'(pred_hit), 32'(last.hit));
        chk("sb_taken", 32'(pred_taken), 32'(last.taken));
        chk("sb_target", pred_target, last.tgt);
        chk("sb_ctr", 32'(pred_ctr), 32'(last.ctr));
    end

    initial begin
        logic [31:0] pa;
        logic [31:0] pb;
        int          cnt;
        pred_t       p;
        pa = 32'h100;
        pb = 32'h100 + 4 * N;
        #1 rst = 1'b0;
        model_clear_all();
        @(posedge clk);
        #1;
        expect_out("reset", 1'b0, 1'b0, 32'h0, 2'd0);
        chk("reset_busy", 32'(busy), 32'd1);
        rst = 1'b1;

        for (int k = 0; k < N; k++) begin
            lookup(pa + 32'(4 * k));
            chk("sweep_lookup_hit", 32'(pred_hit), 32'd0);
        end
        chk("sweep_done_busy", 32'(busy), 32'd0);

        lookup(pa);
        expect_out("idle_miss", 1'b0, 1'b0, 32'h0, 2'd0);

        update(pa, 1'b1, 32'h40, 1'b0, 2'd0);
        lookup(pa);
        expect_out("alloc", 1'b1, 1'b1, 32'h40, 2'b10);

        update(pa, 1'b0, 32'h0, 1'b1, 2'b10);
        lookup(pa);
        expect_out("dec1", 1'b1, 1'b0, 32'h40, 2'b01);
        update(pa, 1'b0, 32'h0, 1'b1, 2'b01);
        lookup(pa);
        expect_out("dec2", 1'b1, 1'b0, 32'h40, 2'b00);
        update(pa, 1'b0, 32'h0, 1'b1, 2'b00);
        lookup(pa);
        expect_out("dec_sat", 1'b1, 1'b0, 32'h40, 2'b00);
        update(pa, 1'b1, 32'h40, 1'b1, 2'b11);
        lookup(pa);
        expect_out("inc_sat", 1'b1, 1'b1, 32'h40, 2'b11);

        lookup(pb);
        expect_out("alias_miss", 1'b0, 1'b0, 32'h0, 2'd0);
        update(pb, 1'b1, 32'h80, 1'b0, 2'd0);
        lookup(pa);
        expect_out("alias_evicted", 1'b0, 1'b0, 32'h0, 2'd0);
        lookup(pb);
        expect_out("alias_new", 1'b1, 1'b1, 32'h80, 2'b10);

        lookup_en  = 1'b1;
        lookup_pc  = pb;
        upd_en     = 1'b1;
        upd_pc     = pb;
        upd_taken  = 1'b1;
        upd_target = 32'hC0;
        upd_hit    = 1'b1;
        upd_ctr    = 2'b10;
        tick();
        expect_out("collide_old", 1'b1, 1'b1, 32'h80, 2'b10);
        lookup(pb);
        expect_out("collide_new", 1'b1, 1'b1, 32'hC0, 2'b11);

        flush      = 1'b1;
        upd_en     = 1'b1;
        upd_pc     = 32'h200;
        upd_taken  = 1'b1;
        upd_target = 32'h44;
        upd_hit    = 1'b0;
        tick();
        repeat (N) tick();
        lookup(32'h200);
        expect_out("flush_drop_upd", 1'b0, 1'b0, 32'h0, 2'd0);
        lookup(pb);
        expect_out("flush_cleared", 1'b0, 1'b0, 32'h0, 2'd0);

        flush = 1'b1;
        tick();
        repeat (7) tick();
        flush = 1'b1;
        tick();
        cnt = 0;
        while (busy && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("flush_restart_len", 32'(cnt), 32'(N));

        update(32'h300, 1'b1, 32'h1234, 1'b0, 2'd0);
        lookup(32'h300);
        expect_out("pre_rst_hit", 1'b1, 1'b1, 32'h1234, 2'b10);
        flush = 1'b1;
        tick();
        repeat (5) tick();
        #2 rst = 1'b0;
        exp_q.delete();
        last = '0;
        model_clear_all();
        #1;
        expect_out("rst_mid_sweep", 1'b0, 1'b0, 32'h0, 2'd0);
        chk("rst_mid_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (N) tick();
        lookup(32'h300);
        expect_out("post_rst_miss", 1'b0, 1'b0, 32'h0, 2'd0);

        for (int r = 0; r < 800; r++) begin
            if ($urandom_range(99) < 70) begin
                lookup_en = 1'b1;
                lookup_pc = ($urandom & 32'hFFFF_C000) | 32'(($urandom_range(2) * N + $urandom_range(N - 1)) * 4)
                            | 32'($urandom_range(3));
            end
            if ($urandom_range(99) < 50) begin
                upd_en     = 1'b1;
                upd_pc     = ($urandom & 32'hFFFF_C000) | 32'(($urandom_range(2) * N + $urandom_range(N - 1)) * 4);
                upd_taken  = 1'($urandom_range(1));
                upd_target = $urandom & 32'hFFFF_FFFC;
                p          = model_look(upd_pc);
                upd_hit    = ($urandom_range(4) != 0) ? p.hit : 1'($urandom_range(1));
                upd_ctr    = ($urandom_range(9) < 7) ? p.ctr : 2'($urandom_range(3));
            end
            flush = ($urandom_range(59) == 0);
            tick();
        end

        tick();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
